regfile_dump_reader: RTL and testbench

//  Debug/trace reader for the 64-bit, 32-entry integer register file. On a start

---
 rtl/riscv_pkg.sv | 14 +
 rtl/regfile_dump_reader.sv | 106 ++++++++++
 tb/tb_regfile_dump_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core parameters and the dump-reader FSM state encoding.
package riscv_pkg;

   localparam int XLEN       = 64;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } dump_state_e;

endpackage : riscv_pkg

// File: rtl/regfile_dump_reader.sv
// Walks x0..x31 through a spare register-file read port and streams each value
// out over valid/ready, tagged with its index, for the debug/trace path.
module regfile_dump_reader
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [REG_ADDR_W-1:0] rf_addr,
   input  logic [XLEN-1:0]       rf_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_data,
   output logic [REG_ADDR_W-1:0] out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

   dump_state_e           state_q,     state_d;
   logic [REG_ADDR_W-1:0] rf_addr_q,   rf_addr_d;
   logic [XLEN-1:0]       out_data_q,  out_data_d;
   logic [REG_ADDR_W-1:0] out_index_q, out_index_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q,  out_last_d;
   logic                  busy_q,      busy_d;
   logic                  done_q,      done_d;

   always_comb begin
      // NOTE: every *_d gets a default before the case so no path leaves one unassigned (no latches).
      state_d     = state_q;
      rf_addr_d   = rf_addr_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A start coinciding with the done pulse belongs to the finished dump.
            if (start && !done_q) begin
               rf_addr_d = '0;
               busy_d    = 1'b1;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            out_data_d  = (rf_addr_q == '0) ? '0 : rf_data;
            out_index_d = rf_addr_q;
            out_valid_d = 1'b1;
            out_last_d  = (rf_addr_q == LAST_IDX);
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  rf_addr_d = rf_addr_q + REG_ADDR_W'(1);
                  state_d   = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments; reset is synchronous and overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rf_addr_q   <= '0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rf_addr_q   <= rf_addr_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign rf_addr   = rf_addr_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader with a behavioural register file beside it.
module tb_regfile_dump_reader;
   import riscv_pkg::*;

   localparam int XL = XLEN;
   localparam int NR = NUM_REGS;
   localparam int AW = REG_ADDR_W;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] rf_addr;
   logic [XL-1:0] rf_data;
   logic          out_valid;
   logic          out_ready;
   logic [XL-1:0] out_data;
   logic [AW-1:0] out_index;
   logic          out_last;
   logic          busy;
   logic          done;

   // Register file: synchronous write, combinational read.
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [XL-1:0] rf_wdata;
   logic [XL-1:0] rf_mem [NR];

   always #5 clk = ~clk;

   always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
   assign rf_data = rf_mem[rf_addr];

   regfile_dump_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      logic [AW-1:0] idx;
      logic [XL-1:0] data;
      logic          last;
   } word_t;

   word_t         exp_q [$];
   logic [XL-1:0] model_regs [NR];
   int            errors = 0;
   int            checks = 0;

   task automatic check(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected word per accepted handshake, checks hold-stability and done.
   logic          done_due = 1'b0;
   logic          hold_active = 1'b0;
   logic [XL-1:0] hold_data;
   logic [AW-1:0] hold_index;
   logic          hold_last;
   word_t         mon_w;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         done_due    = 1'b0;
         hold_active = 1'b0;
      end else begin
         if (done || done_due) begin
            check("done_pulse", 64'(done), 64'(done_due));
            done_due = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got index %0d, expected no word", out_index);
            end else begin
               mon_w = exp_q.pop_front();
               check("out_index", 64'(out_index), 64'(mon_w.idx));
               check("out_data",  out_data,       mon_w.data);
               check("out_last",  64'(out_last),  64'(mon_w.last));
               if (mon_w.last) done_due = 1'b1;
            end
            hold_active = 1'b0;
         end else if (out_valid) begin
            if (hold_active) begin
               check("hold_data",  out_data,       hold_data);
               check("hold_index", 64'(out_index), 64'(hold_index));
               check("hold_last",  64'(out_last),  64'(hold_last));
            end
            hold_data   = out_data;
            hold_index  = out_index;
            hold_last   = out_last;
            hold_active = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input int idx, input logic [XL-1:0] val);
      rf_we    = 1'b1;
      rf_waddr = AW'(idx);
      rf_wdata = val;
      tick();
      rf_we = 1'b0;
      model_regs[idx] = val;
   endtask

   // Expected stream: every index in order, x0 reads as zero, last flag on the final index.
   task automatic push_dump();
      word_t w;
      for (int i = 0; i < NR; i++) begin
         w.idx  = AW'(i);
         w.data = (i == 0) ? '0 : model_regs[i];
         w.last = (i == NR - 1);
         exp_q.push_back(w);
      end
   endtask

   task automatic run_dump(input int stall_idx, input int stall_len, input int restart_idx,
                           input int rst_idx, input int wr_idx, input logic [XL-1:0] wr_val,
                           output int cycles);
      int left    = stall_len;
      bit resent  = 1'b0;
      bit written = 1'b0;
      int n       = 0;
      cycles = -1;
      push_dump();
      out_ready = 1'b1;
      start     = 1'b1;
      forever begin
         tick();
         n++;
         start = 1'b0;
         rf_we = 1'b0;
         if (done) begin
            cycles = n - 1;
            break;
         end
         if (n > 400) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout: got no done after %0d cycles, required within 400", n);
            break;
         end
         out_ready = 1'b1;
         if (out_valid && out_index == stall_idx && left > 0) begin
            out_ready = 1'b0;
            left--;
         end
         if (out_valid && out_index == restart_idx && !resent) begin
            start  = 1'b1;
            resent = 1'b1;
         end
         if (busy && !out_valid && rf_addr == wr_idx && !written) begin
            rf_we    = 1'b1;
            rf_waddr = AW'(wr_idx);
            rf_wdata = wr_val;
            written  = 1'b1;
         end
         if (out_valid && out_index == rst_idx) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("abort_valid",   64'(out_valid), 64'(0));
            check("abort_busy",    64'(busy),      64'(0));
            check("abort_rf_addr", 64'(rf_addr),   64'(0));
            check("abort_done",    64'(done),      64'(0));
            break;
         end
      end
      if (written) model_regs[wr_idx] = wr_val;
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b1;
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      tick();
      for (int i = 0; i < NR; i++) write_reg(i, '0);

      check("rst_valid",     64'(out_valid), 64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_done",      64'(done),      64'(0));
      check("rst_last",      64'(out_last),  64'(0));
      check("rst_rf_addr",   64'(rf_addr),   64'(0));
      check("rst_out_index", 64'(out_index), 64'(0));
      check("rst_out_data",  out_data,       64'(0));
      rst = 1'b0;
      repeat (2) tick();

      // Plain dump with two preloaded registers; timing and end state.
      write_reg(1,  64'h1234_5678_9ABC_DEF0);
      write_reg(10, 64'hFEDC_BA98_7654_3210);
      run_dump(-1, 0, -1, -1, -1, '0, cyc);
      check("dump_cycles", 64'(cyc),        64'(64));
      check("end_rf_addr", 64'(rf_addr),    64'(NR - 1));
      check("end_busy",    64'(busy),       64'(0));
      check("end_queue",   64'(exp_q.size()), 64'(0));
      // start arriving together with done must not begin a new dump.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_on_done_busy", 64'(busy), 64'(0));
      tick();
      check("start_on_done_idle", 64'(busy), 64'(0));
      repeat (2) tick();

      // x0 always reads as zero.
      write_reg(0, 64'h1111_1111_1111_1111);
      run_dump(-1, 0, -1, -1, -1, '0, cyc);
      repeat (2) tick();

      // Backpressure on index 3.
      run_dump(3, 5, -1, -1, -1, '0, cyc);
      check("stall_cycles", 64'(cyc), 64'(69));
      repeat (2) tick();

      // Extra start mid-dump is ignored.
      run_dump(-1, 0, 7, -1, -1, '0, cyc);
      repeat (4) tick();
      check("restart_idle_busy", 64'(busy), 64'(0));

      // Reset during SEND of index 12, then a fresh dump.
      run_dump(-1, 0, -1, 12, -1, '0, cyc);
      repeat (3) tick();
      check("post_abort_valid", 64'(out_valid), 64'(0));
      run_dump(-1, 0, -1, -1, -1, '0, cyc);
      check("fresh_cycles", 64'(cyc), 64'(64));
      repeat (2) tick();

      // Write-back to x5 during its own FETCH cycle is not seen until the next dump.
      write_reg(5, 64'h0000_0000_0000_5555);
      run_dump(-1, 0, -1, -1, 5, 64'hA5A5_A5A5_A5A5_A5A5, cyc);
      repeat (2) tick();
      run_dump(-1, 0, -1, -1, -1, '0, cyc);
      repeat (2) tick();

      // Randomised contents and stall placement.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(1, 0) == 1) write_reg(i, {$urandom(), $urandom()});
         end
         run_dump(int'($urandom_range(NR - 1, 0)), int'($urandom_range(4, 1)),
                  int'($urandom_range(NR - 1, 0)), -1, -1, '0, cyc);
         repeat (int'($urandom_range(3, 1))) tick();
      end

      repeat (3) tick();
      check("final_queue", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_regfile_dump_reader
